// File: rtl/m8_word_serializer.sv
// m8_word_serializer: fetches words from the M8 word filler and shifts them out MSB-first on sdat.
// Optional M8_MANCHESTER_EN: Manchester-codes each bit (1 -> 1,0 ; 0 -> 0,1); CLK_DIV must then be even.
module m8_word_serializer #(
    parameter int CLK_DIV     = 4,
    parameter int WORD_BITS   = 12,
    parameter int FRAME_WORDS = 1024,
    parameter int GROUPS      = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [WORD_BITS-1:0]           dataWord,
    output logic                           bufGetWord,
    output logic [$clog2(FRAME_WORDS)-1:0] bufRdPointer,
    output logic [$clog2(GROUPS)-1:0]      numGrp,
    output logic                           sdat,
    output logic                           bitStrobe,
    output logic                           wordStart,
    output logic                           frameStart,
    output logic                           busy
);
    localparam int PW = $clog2(FRAME_WORDS);
    localparam int GW = $clog2(GROUPS);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(WORD_BITS);

    localparam logic [PW-1:0] PTR_LAST = PW'(FRAME_WORDS - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_BITS - 1);
`ifdef M8_MANCHESTER_EN
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
`endif

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, SHIFT} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         ptr;
    logic [GW-1:0]         grp;
    logic [WORD_BITS-1:0]  shreg;
    logic [WORD_BITS-1:0]  next_word;
    logic                  next_zero;
    logic                  get_d;
    logic [DW-1:0]         div;
    logic [BW-1:0]         bitcnt;

    assign bufRdPointer = ptr;
    assign numGrp       = grp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = FETCH;
                FETCH:   state_nxt = WAIT;
                WAIT:    state_nxt = LOAD;
                LOAD:    state_nxt = SHIFT;
                SHIFT:   state_nxt = SHIFT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        // Each word's first clk prefetches the following word, so exactly one strobe per word.
        bufGetWord = (state == FETCH) || ((state == SHIFT) && wordStart);
        sdat       = 1'b0;
        if (state == SHIFT) begin
`ifdef M8_MANCHESTER_EN
            sdat = (div < DIV_HALF) ? shreg[WORD_BITS-1] : ~shreg[WORD_BITS-1];
`else
            sdat = shreg[WORD_BITS-1];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0; grp <= '0; shreg <= '0; next_word <= '0; next_zero <= 1'b0;
            get_d <= 1'b0; div <= '0; bitcnt <= '0;
            bitStrobe <= 1'b0; wordStart <= 1'b0; frameStart <= 1'b0;
        end else if (state == IDLE || !enable) begin
            ptr <= '0; grp <= '0; shreg <= '0; next_word <= '0; next_zero <= 1'b0;
            get_d <= 1'b0; div <= '0; bitcnt <= '0;
            bitStrobe <= 1'b0; wordStart <= 1'b0; frameStart <= 1'b0;
        end else begin
            bitStrobe  <= 1'b0;
            wordStart  <= 1'b0;
            frameStart <= 1'b0;
            get_d      <= bufGetWord;
            // Group advances with the pointer wrap so numGrp always tags the word being fetched.
            if (bufGetWord) begin
                next_zero <= (ptr == '0);
                if (ptr == PTR_LAST) begin
                    ptr <= '0;
                    grp <= (grp == GRP_LAST) ? '0 : grp + 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
            case (state)
                LOAD: begin
                    shreg      <= dataWord;
                    bitcnt     <= BIT_LAST;
                    div        <= '0;
                    wordStart  <= 1'b1;
                    bitStrobe  <= 1'b1;
                    frameStart <= 1'b1;
                end
                SHIFT: begin
                    if (get_d) next_word <= dataWord;
                    if (div == DIV_LAST) begin
                        div       <= '0;
                        bitStrobe <= 1'b1;
                        if (bitcnt == '0) begin
                            shreg      <= next_word;
                            bitcnt     <= BIT_LAST;
                            wordStart  <= 1'b1;
                            frameStart <= next_zero;
                        end else begin
                            shreg  <= shreg << 1;
                            bitcnt <= bitcnt - 1'b1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/m8_word_serializer.md
Name: m8_word_serializer

Overview:
- Downstream consumer of the M8 word filler.
- Walks the 1024-word phrase pointer and the 32-group counter, and strobes the filler for each word.
- Captures the registered 12-bit word the filler returns and shifts it out MSB-first as a serial telemetry bit stream.
- Double-buffers one word ahead so consecutive words leave back-to-back with no gap bits.

Parameters:
- CLK_DIV, 4: clk cycles per output bit; legal range 2..1023. Even values only when the optional feature is compiled in.
- WORD_BITS, 12: bits per word; matches the filler dataWord width.
- FRAME_WORDS, 1024: words per phrase; the pointer wraps at FRAME_WORDS-1.
- GROUPS, 32: phrases per group cycle; numGrp wraps at GROUPS-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- enable  in  1  run request, level sensitive
- dataWord  in  12  word from the filler; valid from the clk after bufGetWord was high
- bufGetWord  out  1  one-clk fetch strobe to the filler
- bufRdPointer  out  10  word index being fetched
- numGrp  out  5  group index of the word being fetched
- sdat  out  1  serial data
- bitStrobe  out  1  one-clk pulse on the first clk of each bit
- wordStart  out  1  one-clk pulse on the first clk of each word (bit 11)
- frameStart  out  1  one-clk pulse on the first clk of word 0
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: every output and internal register is 0; state is IDLE.
- State sequence: IDLE -> FETCH -> WAIT -> LOAD -> SHIFT.
- IDLE: sdat=0. When enable is sampled 1, go to FETCH.
- FETCH (1 clk): bufGetWord=1, bufRdPointer=0, numGrp=current value. Internal ptr becomes 1.
- WAIT (1 clk): the filler registers dataWord during this clk.
- LOAD (1 clk): on the closing edge, shreg<=dataWord, bit counter<=WORD_BITS-1, divider<=0.
  - sdat shows shreg[11] from that edge onward.
  - wordStart and bitStrobe pulse. frameStart also pulses, since this is word 0.
- SHIFT:
  - Divider counts 0..CLK_DIV-1.
  - At wrap, shift left and decrement the bit counter; bitStrobe pulses on each divider==0.
  - On the first clk of each word: bufGetWord=1, bufRdPointer=ptr, then ptr increments.
  - Two clks after that strobe, nextWord<=dataWord.
  - After bit 0 completes: shreg<=nextWord with no idle clk between words; wordStart pulses.
  - frameStart pulses when the word just loaded was fetched with pointer 0.
- Pointer wrap: when ptr goes FRAME_WORDS-1 -> 0, numGrp increments in the same clk. numGrp goes GROUPS-1 -> 0.
  - numGrp therefore always matches the word being fetched, so the filler's group-gated counters (groups 1, 9, 17, 25) see the correct value.
- bufGetWord rules:
  - Never high in two consecutive clks.
  - Exactly one strobe per serialized word.
  - bufRdPointer and numGrp are stable for the whole strobe clk.
- enable low while busy: on the next edge, go to IDLE; sdat, ptr and numGrp clear to 0. A later enable restarts at word 0, group 0.
- enable high in the same clk as the last bit of a word: normal continuation; no special case.
- Asynchronous reset mid-word: everything returns immediately to reset values; no partial word is completed.
- Width rules:
  - ptr wraps modulo FRAME_WORDS using an explicit compare, not natural overflow.
  - Divider and bit counter are sized by the parameters with $clog2.
- Latency: bit 11 of word 0 appears on sdat 4 rising edges after enable is first sampled high.

Optional Feature:
- Macro: M8_MANCHESTER_EN.
- Defined: each bit is split into two halves of CLK_DIV/2 clks.
  - Bit 1 sends 1 then 0; bit 0 sends 0 then 1.
  - bitStrobe still marks the start of the first half.
  - Fetch and prefetch timing is unchanged.
- Undefined: NRZ; sdat holds the bit level for all CLK_DIV clks.

Test Plan:
- Reset mid-SHIFT, then release; with enable=0 -> all outputs 0, busy=0, no bufGetWord pulses.
- Stub returns {2'b10, bufRdPointer} one clk after the strobe; CLK_DIV=4, enable=1 -> first 12 bits on sdat are 1,0,0,0,0,0,0,0,0,0,0,0 (0x800); second word is 0x801; 48 clks between wordStart pulses.
- Run 1024 words -> bufRdPointer wraps 1023->0; numGrp goes 0->1 on that fetch; frameStart pulses once per 1024 wordStart pulses.
- Run 32 phrases -> numGrp goes 31->0; fetch count equals word count exactly, and bufGetWord is never high in adjacent clks.
- Deassert enable at bit 5 of word 3 -> IDLE on the next edge, sdat=0; re-enable -> FETCH with bufRdPointer=0, numGrp=0.
- M8_MANCHESTER_EN defined, CLK_DIV=4, word 0x800 -> sdat sequence 1,1,0,0 then 0,0,1,1 repeated for the remaining 11 bits.
